// File: rtl/playback_sequencer_pkg.sv
// playback_sequencer_pkg
//   Shared definitions for the playback sequencer: the note encoding
//   (0..NOTE_MAX are notes, anything above is a rest, NOTE_REST is the
//   value a cleared slot holds) and the FSM state encoding.
package playback_sequencer_pkg;

  localparam int NOTE_W = 4;
  localparam logic [NOTE_W-1:0] NOTE_MAX  = 4'd12;
  localparam logic [NOTE_W-1:0] NOTE_REST = 4'hF;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/playback_sequencer_tempo_tick.sv
// tempo_tick
//   Loadable down-counter that times one sequencer step.
//   load loads len-1, so a step lasts exactly len cycles; the counter then
//   decrements to zero and parks there until reloaded or cleared.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   load       load len-1 into the counter
//   clear      force the counter to zero (sequencer going idle)
//   len        step length in cycles (>= 1)
//   tc         terminal count: counter is zero
//   gap        counter is inside the final GAP cycles of the step
//              (constant 0 when GAP is 0)
module tempo_tick #(
  parameter int W   = 25,
  parameter int GAP = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] len,
  output logic         tc,
  output logic         gap
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= len - W'(1);
    end else if (count_reg != '0) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign tc = (count_reg == '0);

  // The counter runs L-1..0, so values below GAP are the last GAP cycles.
  if (GAP == 0) begin : g_no_gap
    assign gap = 1'b0;
  end else begin : g_gap
    assign gap = (count_reg < W'(GAP));
  end

endmodule

// File: rtl/playback_sequencer.sv
// playback_sequencer
//   Tempo-programmable 8-slot step sequencer driving the tone datapath.
//   Holds the note pattern (written at any time) and walks it in IDLE/RUN,
//   presenting note_index and play to the wave generator / I2S controller.
//   Build option: define SEQ_GAP_EN to drop play during the last GAP_CYCLES
//   of every step (articulation gap); otherwise play is continuous.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, stop         one-cycle pulses; stop wins when both are high
//   loop_en             wrap after the last step (sampled at its end)
//   tempo_sel           step length TICK_DIV >> tempo_sel (sampled at step entry)
//   wr_en/addr/data     pattern slot write (13..15 play as rests)
//   note_index, play    tone datapath controls
//   step, busy, done    current step, running flag, one-shot completion pulse
module playback_sequencer
  import playback_sequencer_pkg::*;
#(
  parameter int TICK_DIV   = 25_000_000,
  parameter int NUM_STEPS  = 8,
  parameter int GAP_CYCLES = 2_500_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         loop_en,
  input  logic [1:0]                   tempo_sel,
  input  logic                         wr_en,
  input  logic [$clog2(NUM_STEPS)-1:0] wr_addr,
  input  logic [NOTE_W-1:0]            wr_data,
  output logic [NOTE_W-1:0]            note_index,
  output logic                         play,
  output logic [$clog2(NUM_STEPS)-1:0] step,
  output logic                         busy,
  output logic                         done
);

  localparam int STEP_W = $clog2(NUM_STEPS);
  localparam int CNT_W  = $clog2(TICK_DIV + 1);

`ifdef SEQ_GAP_EN
  localparam int GAP_LEN = GAP_CYCLES;
`else
  localparam int GAP_LEN = 0;
`endif

  if ((TICK_DIV % 8) != 0 || GAP_CYCLES >= TICK_DIV) begin : g_param_check
    $error("playback_sequencer: TICK_DIV must be a multiple of 8 and exceed GAP_CYCLES");
  end

  state_t              state_reg, state_next;
  logic [STEP_W-1:0]   step_reg, step_next;
  logic [NOTE_W-1:0]   note_reg, note_next;
  logic                is_note_reg, is_note_next;
  logic                done_reg, done_next;
  logic                load, clear, tc, gap;
  logic [CNT_W-1:0]    len;
  logic [NOTE_W-1:0]   slot_data;
  logic [NOTE_W-1:0]   pattern_mem [NUM_STEPS];

  assign len = CNT_W'(TICK_DIV >> tempo_sel);

  tempo_tick #(
    .W   (CNT_W),
    .GAP (GAP_LEN)
  ) u_tempo_tick (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .clear (clear),
    .len   (len),
    .tc    (tc),
    .gap   (gap)
  );

  // Pattern store. The FSM reads it combinationally in the same cycle a
  // write may land, so a colliding read sees the old contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        pattern_mem[i] <= NOTE_REST;
      end
    end else if (wr_en) begin
      pattern_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      step_reg    <= '0;
      note_reg    <= '0;
      is_note_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      step_reg    <= step_next;
      note_reg    <= note_next;
      is_note_reg <= is_note_next;
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    step_next    = step_reg;
    note_next    = note_reg;
    is_note_next = is_note_reg;
    done_next    = 1'b0;
    load         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start && !stop) begin
          state_next = RUN;
          step_next  = '0;
          load       = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_next = IDLE;
        end else if (start) begin
          step_next = '0;
          load      = 1'b1;
        end else if (tc) begin
          if (step_reg == STEP_W'(NUM_STEPS - 1) && !loop_en) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            step_next = step_reg + STEP_W'(1);
            load      = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Step entry: a rest keeps the previous note_index and only mutes play.
    slot_data = pattern_mem[step_next];
    if (load) begin
      is_note_next = (slot_data <= NOTE_MAX);
      if (slot_data <= NOTE_MAX) begin
        note_next = slot_data;
      end
    end
  end

  // Parking the timer at zero keeps a stale count from leaking into the
  // gap window of the next run.
  assign clear = (state_next == IDLE);

  assign busy       = (state_reg == RUN);
  assign step       = step_reg;
  assign note_index = note_reg;
  assign done       = done_reg;
  assign play       = busy & is_note_reg & ~gap;

endmodule

// File: tb/tb_playback_sequencer.sv
// tb_playback_sequencer
//   Directed scenarios for playback_sequencer with TICK_DIV=16,
//   NUM_STEPS=8, GAP_CYCLES=2. Stimulus pushes the expected output changes
//   (cycle stamp plus busy/step/note/play/done) into a queue; a monitor pops
//   one entry whenever the observed output tuple changes.
module tb_playback_sequencer;

  localparam int TICK_DIV = 16;
  localparam int GAP      = 2;
`ifdef SEQ_GAP_EN
  localparam bit GAP_BUILD = 1'b1;
`else
  localparam bit GAP_BUILD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       loop_en = 1'b0;
  logic [1:0] tempo_sel = 2'd0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic [3:0] wr_data = 4'd0;
  logic [3:0] note_index;
  logic       play;
  logic [2:0] step;
  logic       busy;
  logic       done;

  playback_sequencer #(
    .TICK_DIV   (TICK_DIV),
    .NUM_STEPS  (8),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .loop_en    (loop_en),
    .tempo_sel  (tempo_sel),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .note_index (note_index),
    .play       (play),
    .step       (step),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string      name;
    int         cyc;
    logic       busy;
    logic [2:0] step;
    logic [3:0] note;
    logic       play;
    logic       done;
  } exp_t;

  exp_t       expq[$];
  int         checks = 0;
  int         failures = 0;
  string      tname;
  logic [3:0] pat[8];
  logic [3:0] mnote;
  logic [3:0] scale[8] = '{4'd0, 4'd2, 4'd4, 4'd5, 4'd7, 4'd9, 4'd11, 4'd12};

  task automatic push(input int t, input logic b, input int s, input logic [3:0] n,
                      input logic p, input logic d);
    exp_t x;
    x.name = tname;
    x.cyc  = t;
    x.busy = b;
    x.step = 3'(s);
    x.note = n;
    x.play = p;
    x.done = d;
    expq.push_back(x);
  endtask

  // Expected changes for a run started at edge e with step length len.
  // kind: 0 = cut at end_at with no record (restart follows), 1 = one-shot
  // to completion, 2 = stopped at end_at, 3 = reset at end_at.
  // A write of wr_v to slot wr_s sampled at edge wr_t is seen only by step
  // entries strictly after wr_t.
  task automatic push_run(input int e, input int len, input int n, input int end_at,
                          input int kind, input int wr_t, input int wr_s,
                          input logic [3:0] wr_v);
    int         t;
    int         s_last;
    logic [3:0] v;
    bit         pl;
    s_last = 0;
    for (int s = 0; s < n; s++) begin
      t = e + s * len;
      if (kind != 1 && t >= end_at) break;
      s_last = s % 8;
      v = (s_last == wr_s && t > wr_t) ? wr_v : pat[s_last];
      pl = (v <= 4'd12);
      if (pl) mnote = v;
      if (GAP_BUILD) pl = pl && (len > GAP);
      push(t, 1'b1, s_last, mnote, pl, 1'b0);
      if (GAP_BUILD && pl && (kind == 1 || t + len - GAP < end_at))
        push(t + len - GAP, 1'b1, s_last, mnote, 1'b0, 1'b0);
    end
    case (kind)
      1: begin
        push(e + n * len, 1'b0, s_last, mnote, 1'b0, 1'b1);
        push(e + n * len + 1, 1'b0, s_last, mnote, 1'b0, 1'b0);
      end
      2: push(end_at, 1'b0, s_last, mnote, 1'b0, 1'b0);
      3: begin
        push(end_at, 1'b0, 0, 4'd0, 1'b0, 1'b0);
        mnote = 4'd0;
      end
      default: ;
    endcase
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [1:0] ts, input logic le);
    tempo_sel = ts;
    loop_en   = le;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic write_slot(input int a, input logic [3:0] d);
    wr_en   = 1'b1;
    wr_addr = 3'(a);
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    pat[a] = d;
  endtask

  // Monitor: one comparison per change of the output tuple.
  logic [9:0] prev_obs;
  bit         seen = 1'b0;
  always @(negedge clk) begin
    logic [9:0] obs;
    exp_t       x;
    obs = {busy, step, note_index, play, done};
    if (!seen || obs != prev_obs) begin
      seen = 1'b1;
      prev_obs = obs;
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_change cyc=%0d got busy=%b step=%0d note=%0d play=%b done=%b, required no change",
                 cyc, busy, step, note_index, play, done);
      end else begin
        x = expq.pop_front();
        if (cyc != x.cyc || busy !== x.busy || step !== x.step || note_index !== x.note ||
            play !== x.play || done !== x.done) begin
          failures++;
          $display("FAIL %s got cyc=%0d busy=%b step=%0d note=%0d play=%b done=%b required cyc=%0d busy=%b step=%0d note=%0d play=%b done=%b",
                   x.name, cyc, busy, step, note_index, play, done,
                   x.cyc, x.busy, x.step, x.note, x.play, x.done);
        end else begin
          $display("ok %s cyc=%0d busy=%b step=%0d note=%0d play=%b done=%b",
                   x.name, cyc, busy, step, note_index, play, done);
        end
      end
    end
  end

  initial begin
    int e;
    for (int i = 0; i < 8; i++) pat[i] = 4'hF;
    mnote = 4'd0;

    tname = "reset";
    push(1, 1'b0, 0, 4'd0, 1'b0, 1'b0);
    wait_until(3);
    rst = 1'b0;
    wait_until(5);

    // Empty pattern, slowest tempo, one-shot: 128 cycles of silence.
    tname = "rest_oneshot";
    e = cyc + 1;
    push_run(e, 16, 8, 0, 1, 0, -1, 4'd0);
    pulse_start(2'd0, 1'b0);
    wait_until(e + 140);

    // Scale at tempo 2 (L=4), one-shot.
    tname = "scale_oneshot";
    for (int i = 0; i < 8; i++) write_slot(i, scale[i]);
    e = cyc + 1;
    push_run(e, 4, 8, 0, 1, 0, -1, 4'd0);
    pulse_start(2'd2, 1'b0);
    wait_until(e + 40);

    // Loop at tempo 1 (L=8): wraps 7->0 at 64, stop lands on a step boundary.
    tname = "loop_wrap_stop";
    e = cyc + 1;
    push_run(e, 8, 16, e + 72, 2, 0, -1, 4'd0);
    pulse_start(2'd1, 1'b1);
    wait_until(e + 71);
    pulse_stop();
    wait_until(e + 80);

    // start and stop together while running: idle, no restart.
    tname = "start_stop_same";
    e = cyc + 1;
    push_run(e, 4, 8, e + 5, 2, 0, -1, 4'd0);
    pulse_start(2'd2, 1'b0);
    wait_until(e + 4);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    wait_until(e + 30);

    // Rest written to slot 3 on the very edge step 3 is entered.
    tname = "midrun_write";
    e = cyc + 1;
    push_run(e, 4, 16, e + 52, 2, e + 12, 3, 4'd13);
    pulse_start(2'd2, 1'b1);
    wait_until(e + 11);
    write_slot(3, 4'd13);
    wait_until(e + 51);
    pulse_stop();
    wait_until(e + 60);

    // Reset mid-run clears outputs and pattern.
    tname = "reset_midrun";
    e = cyc + 1;
    push_run(e, 16, 16, e + 20, 3, 0, -1, 4'd0);
    pulse_start(2'd0, 1'b1);
    wait_until(e + 19);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) pat[i] = 4'hF;
    wait_until(e + 30);

    // Repeated note: continuous play, or 14 high / 2 low with the gap.
    tname = "repeat_note";
    for (int i = 0; i < 8; i++) write_slot(i, 4'd5);
    e = cyc + 1;
    push_run(e, 16, 8, 0, 1, 0, -1, 4'd0);
    pulse_start(2'd0, 1'b0);
    wait_until(e + 140);

    // start while running restarts from step 0 with a fresh full run.
    tname = "restart";
    e = cyc + 1;
    push_run(e, 2, 8, e + 5, 0, 0, -1, 4'd0);
    push_run(e + 5, 2, 8, 0, 1, 0, -1, 4'd0);
    pulse_start(2'd3, 1'b0);
    wait_until(e + 4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(e + 30);

    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL leftover_expectations got %0d pending required 0 (next %s at cyc=%0d)",
               expq.size(), expq[0].name, expq[0].cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
